// File: rtl/cache_miss_ctrl.sv
// Miss-handling sequencer between the line cache and main memory.
// Accepts one miss at a time, writes back a dirty victim first, then fetches
// the requested line and hands it to the cache with a one-cycle fill pulse.
// A per-transaction watchdog parks the controller in ERR if memory hangs.
module cache_miss_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 512,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0] victim_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB   = 3'd1,
        ST_RD   = 3'd2,
        ST_FILL = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [15:0]       TIMEOUT_C   = 16'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX_C   = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] LINE_MASK_C = {{(ADDR_W-6){1'b1}}, 6'b000000};

    // Saturating increment: statistics stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX_C) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Line-align a byte address (64-byte lines).
    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        line_of = a & LINE_MASK_C;
    endfunction

    state_t              state_r, state_s;
    logic [15:0]         wd_r, wd_s, wd_inc_s;
    logic                timeout_s;
    logic [ADDR_W-1:0]   miss_line_r, miss_line_s;
    logic                mem_req_s, mem_we_s, fill_valid_s, err_s, miss_ready_s;
    logic [ADDR_W-1:0]   mem_addr_s, fill_addr_s;
    logic [LINE_W-1:0]   mem_wdata_s, fill_data_s;
    logic [CNT_W-1:0]    miss_cnt_s, wb_cnt_s;

    assign wd_inc_s  = wd_r + 16'd1;
    assign timeout_s = (wd_inc_s == TIMEOUT_C);

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s      = state_r;
        wd_s         = wd_r;
        miss_line_s  = miss_line_r;
        mem_req_s    = mem_req;
        mem_we_s     = mem_we;
        mem_addr_s   = mem_addr;
        mem_wdata_s  = mem_wdata;
        fill_valid_s = 1'b0;
        fill_addr_s  = fill_addr;
        fill_data_s  = fill_data;
        miss_cnt_s   = miss_cnt;
        wb_cnt_s     = wb_cnt;
        // err_clr drops the flag anywhere; a timeout below re-asserts it.
        if (err_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err;
        end

        case (state_r)
            ST_IDLE: begin
                if (miss_valid && miss_ready) begin
                    miss_cnt_s  = sat_inc(miss_cnt);
                    miss_line_s = line_of(miss_addr);
                    mem_req_s   = 1'b1;
                    wd_s        = 16'd0;
                    if (victim_dirty) begin
                        state_s     = ST_WB;
                        mem_we_s    = 1'b1;
                        mem_addr_s  = line_of(victim_addr);
                        mem_wdata_s = victim_data;
                    end else begin
                        state_s    = ST_RD;
                        mem_we_s   = 1'b0;
                        mem_addr_s = line_of(miss_addr);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WB: begin
                if (!mem_req) begin
                    mem_req_s = 1'b1;
                    wd_s      = 16'd0;
                end else if (mem_ack) begin
                    // Request drops here, giving one idle cycle before the read.
                    mem_req_s = 1'b0;
                    wb_cnt_s  = sat_inc(wb_cnt);
                    state_s   = ST_RD;
                end else if (timeout_s) begin
                    mem_req_s = 1'b0;
                    err_s     = 1'b1;
                    state_s   = ST_ERR;
                end else begin
                    wd_s = wd_inc_s;
                end
            end
            ST_RD: begin
                if (!mem_req) begin
                    mem_req_s  = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = miss_line_r;
                    wd_s       = 16'd0;
                end else if (mem_ack) begin
                    mem_req_s    = 1'b0;
                    fill_data_s  = mem_rdata;
                    fill_addr_s  = miss_line_r;
                    fill_valid_s = 1'b1;
                    state_s      = ST_FILL;
                end else if (timeout_s) begin
                    mem_req_s = 1'b0;
                    err_s     = 1'b1;
                    state_s   = ST_ERR;
                end else begin
                    wd_s = wd_inc_s;
                end
            end
            ST_FILL: begin
                state_s = ST_IDLE;
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase

        miss_ready_s = (state_s == ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs, watchdog and captured miss line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_r        <= 16'd0;
            miss_line_r <= {ADDR_W{1'b0}};
            miss_ready  <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {LINE_W{1'b0}};
            fill_valid  <= 1'b0;
            fill_addr   <= {ADDR_W{1'b0}};
            fill_data   <= {LINE_W{1'b0}};
            err         <= 1'b0;
            miss_cnt    <= {CNT_W{1'b0}};
            wb_cnt      <= {CNT_W{1'b0}};
        end else begin
            wd_r        <= wd_s;
            miss_line_r <= miss_line_s;
            miss_ready  <= miss_ready_s;
            mem_req     <= mem_req_s;
            mem_we      <= mem_we_s;
            mem_addr    <= mem_addr_s;
            mem_wdata   <= mem_wdata_s;
            fill_valid  <= fill_valid_s;
            fill_addr   <= fill_addr_s;
            fill_data   <= fill_data_s;
            err         <= err_s;
            miss_cnt    <= miss_cnt_s;
            wb_cnt      <= wb_cnt_s;
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: directed scenarios plus randomized
// misses checked against a transaction-level model of the miss timeline.
module tb_cache_miss_ctrl;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 512;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              miss_valid = 1'b0;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr = 32'd0;
    logic              victim_dirty = 1'b0;
    logic [ADDR_W-1:0] victim_addr = 32'd0;
    logic [LINE_W-1:0] victim_data = 512'd0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [LINE_W-1:0] mem_rdata = 512'd0;
    logic              fill_valid;
    logic [ADDR_W-1:0] fill_addr;
    logic [LINE_W-1:0] fill_data;
    logic              err;
    logic              err_clr = 1'b0;
    logic [CNT_W-1:0]  miss_cnt;
    logic [CNT_W-1:0]  wb_cnt;

    int checks = 0;
    int errors = 0;
    int exp_miss = 0;
    int exp_wb = 0;

    cache_miss_ctrl #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .err(err), .err_clr(err_clr), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                            input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] line_a(input logic [31:0] a);
        return a & 32'hFFFF_FFC0;
    endfunction

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called at a negedge: asserts reset and checks every output's reset value.
    task automatic do_reset();
        rst_n = 1'b0;
        miss_valid = 1'b0;
        mem_ack = 1'b0;
        err_clr = 1'b0;
        #1;
        exp_miss = 0;
        exp_wb = 0;
        check_eq("rst_ready", miss_ready, 1'b1);
        check_eq("rst_req", mem_req, 1'b0);
        check_eq("rst_we", mem_we, 1'b0);
        check_eq("rst_fill", fill_valid, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_maddr", mem_addr, 32'd0);
        check_eq("rst_wdata", mem_wdata, 512'd0);
        check_eq("rst_faddr", fill_addr, 32'd0);
        check_eq("rst_fdata", fill_data, 512'd0);
        check_eq("rst_mcnt", miss_cnt, 2'd0);
        check_eq("rst_wcnt", wb_cnt, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presents a miss and waits for acceptance; returns at the negedge after it.
    task automatic accept_miss(input logic [31:0] ma, input logic dirty,
                               input logic [31:0] va, input logic [LINE_W-1:0] vd,
                               input bit hold);
        int cyc = 0;
        miss_valid = 1'b1;
        miss_addr = ma;
        victim_dirty = dirty;
        victim_addr = va;
        victim_data = vd;
        while (miss_ready !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("ready_wait", (cyc < 40), 1'b1);
        @(negedge clk);
        exp_miss = sat(exp_miss);
        check_eq("accept_ready_drop", miss_ready, 1'b0);
        check_eq("accept_miss_cnt", miss_cnt, exp_miss[CNT_W-1:0]);
        if (!hold) miss_valid = 1'b0;
        miss_addr = $urandom;
        victim_addr = $urandom;
        victim_dirty = 1'(($urandom % 2));
        victim_data = rand_line();
    endtask

    // One memory transaction; lat = cycles of mem_req before the ack.
    // Returns at the negedge after the ack (ok=1) or at the timeout point (ok=0).
    task automatic mem_phase(input bit we, input logic [31:0] addr,
                             input logic [LINE_W-1:0] wdata, input int lat,
                             input logic [LINE_W-1:0] rdata, output bit ok);
        int n = 0;
        bit done = 1'b0;
        ok = 1'b0;
        while (!done) begin
            if (n == TIMEOUT) begin
                check_eq("to_req_drop", mem_req, 1'b0);
                check_eq("to_err", err, 1'b1);
                check_eq("to_ready", miss_ready, 1'b0);
                check_eq("to_fill", fill_valid, 1'b0);
                done = 1'b1;
            end else begin
                check_eq(we ? "wb_req" : "rd_req", mem_req, 1'b1);
                check_eq("mem_we", mem_we, we);
                check_eq(we ? "wb_addr" : "rd_addr", mem_addr, addr);
                if (we) check_eq("wb_wdata", mem_wdata, wdata);
                check_eq("busy_fill", fill_valid, 1'b0);
                if (n == lat) begin
                    mem_ack = 1'b1;
                    if (!we) mem_rdata = rdata;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    mem_rdata = rand_line();
                    check_eq("ack_req_drop", mem_req, 1'b0);
                    ok = 1'b1;
                    done = 1'b1;
                end else begin
                    mem_rdata = rand_line();
                    @(negedge clk);
                    n++;
                end
            end
        end
    endtask

    // Complete miss: acceptance, optional write-back, read, fill or timeout recovery.
    task automatic run_miss(input logic [31:0] ma, input logic dirty,
                            input logic [31:0] va, input logic [LINE_W-1:0] vd,
                            input int wlat, input int rlat,
                            input logic [LINE_W-1:0] rdata, input bit hold);
        bit ok = 1'b1;
        int n;
        accept_miss(ma, dirty, va, vd, hold);
        if (dirty) begin
            mem_phase(1'b1, line_a(va), vd, wlat, 512'd0, ok);
            if (ok) begin
                exp_wb = sat(exp_wb);
                check_eq("wb_cnt", wb_cnt, exp_wb[CNT_W-1:0]);
                check_eq("gap_fill", fill_valid, 1'b0);
                @(negedge clk);
            end
        end
        if (ok) begin
            mem_phase(1'b0, line_a(ma), 512'd0, rlat, rdata, ok);
            if (ok) begin
                check_eq("fill_pulse", fill_valid, 1'b1);
                check_eq("fill_addr", fill_addr, line_a(ma));
                check_eq("fill_data", fill_data, rdata);
                check_eq("fill_wb_cnt", wb_cnt, exp_wb[CNT_W-1:0]);
                check_eq("fill_ready", miss_ready, 1'b0);
                @(negedge clk);
                check_eq("fill_end", fill_valid, 1'b0);
                check_eq("ready_back", miss_ready, 1'b1);
            end
        end
        if (!ok) begin
            check_eq("to_wb_cnt", wb_cnt, exp_wb[CNT_W-1:0]);
            n = $urandom_range(0, 3);
            repeat (n) begin
                mem_ack = 1'(($urandom % 2));
                @(negedge clk);
                mem_ack = 1'b0;
                check_eq("err_hold", err, 1'b1);
                check_eq("err_ready", miss_ready, 1'b0);
                check_eq("err_fill", fill_valid, 1'b0);
                check_eq("err_req", mem_req, 1'b0);
            end
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            check_eq("clr_err", err, 1'b0);
            check_eq("clr_ready", miss_ready, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Directed clean miss.
        run_miss(32'h0000_D83F, 1'b0, 32'h0, 512'd0, 0, 3, 512'd3289, 1'b0);
        check_eq("clean_mcnt", miss_cnt, 2'd1);
        check_eq("clean_wcnt", wb_cnt, 2'd0);

        // Directed dirty miss.
        do_reset();
        run_miss(32'h0002_3EB4, 1'b1, 32'h0000_67B4, 512'hABCD, 2, 2, rand_line(), 1'b0);
        check_eq("dirty_mcnt", miss_cnt, 2'd1);
        check_eq("dirty_wcnt", wb_cnt, 2'd1);

        // Timeout on a clean read, then a normal miss.
        run_miss(32'h0000_1234, 1'b0, 32'h0, 512'd0, 0, 100, 512'd0, 1'b0);
        run_miss(32'h0000_5678, 1'b0, 32'h0, 512'd0, 0, 1, rand_line(), 1'b0);
        // Timeout during a write-back: no wb_cnt increment.
        run_miss(32'h0000_9ABC, 1'b1, 32'h0000_4444, rand_line(), 100, 0, 512'd0, 1'b0);
        // Ack on the last allowed cycle still succeeds.
        run_miss(32'h0000_7777, 1'b1, 32'h0000_8888, rand_line(), TIMEOUT - 1, TIMEOUT - 1,
                 rand_line(), 1'b0);

        // Back-to-back with miss_valid held high.
        do_reset();
        for (int i = 0; i < 3; i++)
            run_miss(32'h0010_0000 + 32'(i * 64), 1'b0, 32'h0, 512'd0, 0, 1, rand_line(), 1'b1);
        miss_valid = 1'b0;
        check_eq("b2b_mcnt", miss_cnt, 2'd3);
        @(negedge clk);
        check_eq("b2b_idle_req", mem_req, 1'b0);
        check_eq("b2b_idle_ready", miss_ready, 1'b1);

        // Reset in the middle of a write-back, then a stale ack.
        do_reset();
        accept_miss(32'h0000_ABC0, 1'b1, 32'h0000_CDE0, rand_line(), 1'b0);
        repeat (2) @(negedge clk);
        check_eq("mid_req", mem_req, 1'b1);
        do_reset();
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("stale_fill", fill_valid, 1'b0);
        check_eq("stale_req", mem_req, 1'b0);
        check_eq("stale_ready", miss_ready, 1'b1);
        check_eq("stale_wcnt", wb_cnt, 2'd0);
        @(negedge clk);
        check_eq("stale_fill2", fill_valid, 1'b0);

        // Saturation: five dirty misses.
        do_reset();
        for (int i = 0; i < 5; i++)
            run_miss($urandom, 1'b1, $urandom, rand_line(), $urandom_range(0, 3),
                     $urandom_range(0, 3), rand_line(), 1'b0);
        check_eq("sat_mcnt", miss_cnt, 2'd3);
        check_eq("sat_wcnt", wb_cnt, 2'd3);

        // Randomized misses, occasional stray acks while idle.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                check_eq("idle_ack_fill", fill_valid, 1'b0);
                check_eq("idle_ack_req", mem_req, 1'b0);
                check_eq("idle_ack_ready", miss_ready, 1'b1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_miss($urandom, 1'(($urandom % 2)), $urandom, rand_line(),
                     $urandom_range(0, 9), $urandom_range(0, 9), rand_line(), 1'b0);
            if (i == 20) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Miss-handling sequencer between the 512-bit-line cache and main memory. It accepts one miss at a time from the cache. If the victim line is dirty, it writes that line back first. It then fetches the requested line, returns it to the cache with a one-cycle fill pulse, and keeps saturating statistics. A watchdog per memory transaction flags a hung memory.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 512, line data width in bits (64-byte lines, offset = addr[5:0])
TIMEOUT, 255, max cycles waiting for mem_ack per transaction (1..65535)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_valid  in  1  cache presents a miss
miss_ready  out  1  controller can accept a miss (IDLE only)
miss_addr  in  ADDR_W  requested byte address
victim_dirty  in  1  victim line needs write-back
victim_addr  in  ADDR_W  victim line byte address
victim_data  in  LINE_W  victim line contents
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write-back, 0 = line read
mem_addr  out  ADDR_W  line-aligned memory address
mem_wdata  out  LINE_W  write-back data
mem_ack  in  1  one-cycle completion from memory
mem_rdata  in  LINE_W  read data, valid with mem_ack when mem_we=0
fill_valid  out  1  one-cycle pulse: fill_data is ready for the cache
fill_addr  out  ADDR_W  line-aligned address of the fill
fill_data  out  LINE_W  fetched line
err  out  1  sticky timeout flag
err_clr  in  1  clears err, releases ERR state
miss_cnt  out  CNT_W  accepted misses, saturating
wb_cnt  out  CNT_W  completed write-backs, saturating

Behaviour:
- Reset state (asynchronous, rst_n low):
  - State is IDLE.
  - miss_ready = 1.
  - mem_req, mem_we, fill_valid and err are 0.
  - mem_addr, mem_wdata, fill_addr, fill_data, miss_cnt, wb_cnt and the watchdog are all 0.
  - Reset mid-transaction abandons it with no fill pulse.
- All outputs are registered.
- Addresses are captured with bits [5:0] forced to 0.
- States: IDLE, WB, RD, FILL, ERR.
- IDLE:
  - miss_ready = 1.
  - On miss_valid & miss_ready, capture miss_addr, victim_addr, victim_data and victim_dirty, and increment miss_cnt.
  - Next state is WB if victim_dirty, else RD.
  - miss_ready drops in the cycle after acceptance.
- WB:
  - Drive mem_req=1, mem_we=1, mem_addr=victim line, mem_wdata=victim_data, starting the cycle after entry.
  - On mem_ack: mem_req drops the next cycle, wb_cnt increments, and the state moves to RD.
  - mem_req must be low for at least one cycle between the write-back and the read.
- RD:
  - Drive mem_req=1, mem_we=0, mem_addr=miss line.
  - On mem_ack: capture mem_rdata into fill_data, then go to FILL.
- FILL:
  - fill_valid=1 for exactly one cycle, with fill_addr = miss line.
  - Next state is IDLE; miss_ready returns the following cycle.
- Latency, clean miss accepted at cycle 0:
  - mem_req high at cycle 1.
  - With ack at cycle k, fill_valid at k+1 and miss_ready at k+2.
  - Dirty miss adds the write-back ack time plus 1 idle cycle.
- Watchdog:
  - Resets to 0 on each mem_req rise.
  - Increments every cycle that mem_req=1 and mem_ack=0.
  - Reaching TIMEOUT: drop mem_req, set err, go to ERR. No fill pulse, and no wb_cnt increment.
  - mem_ack in the same cycle as the count reaching TIMEOUT counts as success.
- ERR:
  - miss_ready=0, err=1.
  - err_clr moves to IDLE and clears err the next cycle.
  - In any other state, err_clr clears only the err flag (no-op while err=0).
- mem_ack outside WB/RD, or while mem_req=0, is ignored.
- Counters saturate at all-ones and never wrap.
- miss_valid while miss_ready=0 is ignored; the cache must hold it.
- Inputs are sampled only at acceptance. Changes to victim_data or miss_addr after acceptance have no effect.

Test Plan:
- Clean miss: miss_addr=0x0000_D83F, victim_dirty=0, mem_ack 3 cycles after mem_req, mem_rdata=3289 -> one RD with mem_addr=0x0000_D800, mem_we=0, fill_valid 1 cycle after ack with fill_data=3289, miss_cnt=1, wb_cnt=0.
- Dirty miss: victim_addr=0x0000_67B4, victim_data=0xABCD, miss_addr=0x0002_3EB4 -> WB at 0x0000_6780 with mem_wdata=0xABCD, ≥1 low cycle, then RD at 0x0002_3E80, one fill pulse, miss_cnt=1, wb_cnt=1.
- Timeout: TIMEOUT=8, never ack -> mem_req high exactly 8 cycles, err=1, miss_ready=0, no fill_valid; err_clr pulse -> IDLE, err=0, next miss completes normally.
- Back-to-back: miss_valid held high across 3 misses, ack 1 cycle after each req -> exactly 3 accepts (on miss_ready high only), 3 fill pulses in order, miss_cnt=3.
- Reset mid-operation: rst_n low during WB wait -> all outputs at reset values immediately, mem_req=0; a stale mem_ack after reset produces no fill_valid.
- Saturation: CNT_W=2, 5 dirty misses -> miss_cnt=3 and wb_cnt=3, no wrap.
